// File: rtl/risc_pe_pkg.sv
// Shared definitions for the RISC-V PE datapath: data width, pipeline-stage
// occupancy states and a state-to-level helper.
package risc_pe_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned LEVEL_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Occupancy reported on the level port for a given buffer state.
  function automatic logic [LEVEL_W-1:0] state_level(input pipe_state_t s);
    case (s)
      EMPTY:   return LEVEL_W'(0);
      BUSY:    return LEVEL_W'(1);
      FULL:    return LEVEL_W'(2);
      default: return LEVEL_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready pipeline-stage bus: upstream push side, downstream pop side,
// squash and occupancy. The stage itself uses the slave view.
interface pipe_stage_reg_if
  import risc_pe_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) ();

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic [LEVEL_W-1:0] level;

  modport master (
    output flush,
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  level
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out,
    output level
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake and synchronous flush.
// SKID=1 adds a second entry so in_ready is a flop without throughput loss.
module pipe_stage_reg
  import risc_pe_pkg::*;
#(
  parameter int unsigned      WIDTH       = XLEN,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      SKID        = 1
) (
  input  logic             clock,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus
);

  if (SKID != 0) begin : g_skid

    pipe_state_t        state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [LEVEL_W-1:0] level_q;
    logic               in_fire_c;
    logic               out_fire_c;

    assign in_fire_c  = bus.in_valid & in_ready_q;
    assign out_fire_c = out_valid_q & bus.out_ready;

    // State and datapath registers; ready/valid/level are precomputed from state_d.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q     <= EMPTY;
        main_q      <= RESET_VALUE;
        skid_q      <= RESET_VALUE;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        level_q     <= LEVEL_W'(0);
      end else begin
        state_q     <= state_d;
        main_q      <= main_d;
        skid_q      <= skid_d;
        in_ready_q  <= (state_d != FULL);
        out_valid_q <= (state_d != EMPTY);
        level_q     <= state_level(state_d);
      end
    end

    // Next-state and data steering; flush squashes occupancy but leaves data_out.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        EMPTY: begin
          if (in_fire_c) begin
            state_d = BUSY;
            main_d  = bus.data_in;
          end
        end
        BUSY: begin
          if (in_fire_c && out_fire_c) begin
            main_d = bus.data_in;
          end else if (in_fire_c) begin
            state_d = FULL;
            skid_d  = bus.data_in;
          end else if (out_fire_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire_c) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (bus.flush) begin
        state_d = EMPTY;
        main_d  = main_q;
        skid_d  = skid_q;
      end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = main_q;
    assign bus.level     = level_q;

  end else begin : g_single

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_ready_c;
    logic             in_fire_c;
    logic             out_fire_c;

    // Ready passes straight through from downstream in the single-entry variant.
    assign in_ready_c = ~valid_q | bus.out_ready;
    assign in_fire_c  = bus.in_valid & in_ready_c;
    assign out_fire_c = valid_q & bus.out_ready;

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VALUE;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (bus.flush) begin
        valid_d = 1'b0;
      end else if (in_fire_c) begin
        valid_d = 1'b1;
        main_d  = bus.data_in;
      end else if (out_fire_c) begin
        valid_d = 1'b0;
      end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.data_out  = main_q;
    assign bus.level     = {1'b0, valid_q};

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg with and without the skid entry,
// using a per-instance FIFO scoreboard of accepted words.
module tb_pipe_stage_reg;
  import risc_pe_pkg::*;

  localparam logic [31:0] RV1 = 32'h0BAD_F00D;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        hold      [2];
  logic [31:0] hold_data [2];
  logic        fired     [2];
  int          recv      [2];

  pipe_stage_reg_if #(.WIDTH(32)) b0 ();
  pipe_stage_reg_if #(.WIDTH(32)) b1 ();

  pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(32'h0), .SKID(1)) u_skid (
    .clock (clk),
    .reset (rst),
    .bus   (b0)
  );

  pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV1), .SKID(0)) u_single (
    .clock (clk),
    .reset (rst),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard update for instance k from the values seen just before the edge.
  task automatic sb(input int k, input logic iv, input logic ir, input logic ov,
                    input logic ordy, input logic fl, input logic rs,
                    input logic [31:0] din, input logic [31:0] dout);
    logic [31:0] exp;
    if (hold[k]) begin
      chk($sformatf("hold_valid%0d", k), 32'(ov), 32'd1);
      chk($sformatf("hold_data%0d", k), dout, hold_data[k]);
    end
    hold[k]      = ov & ~ordy & ~fl & ~rs;
    hold_data[k] = dout;
    fired[k]     = 1'b0;
    if (!rs && ov && ordy) begin
      if (k == 0) begin
        chk("sb_nonempty0", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          exp = q0.pop_front();
          chk("sb_data0", dout, exp);
        end
      end else begin
        chk("sb_nonempty1", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          exp = q1.pop_front();
          chk("sb_data1", dout, exp);
        end
      end
      recv[k]++;
    end
    if (rs || fl) begin
      if (k == 0) q0.delete();
      else        q1.delete();
    end else if (iv && ir) begin
      if (k == 0) q0.push_back(din);
      else        q1.push_back(din);
      fired[k] = 1'b1;
    end
  endtask

  // One clock cycle: drive at negedge, score, then land #1 after the posedge.
  task automatic cyc(input logic iv0, input logic [31:0] d0, input logic iv1,
                     input logic [31:0] d1, input logic or0, input logic or1,
                     input logic fl, input logic rs);
    @(negedge clk);
    rst          = rs;
    b0.in_valid  = iv0;
    b0.data_in   = d0;
    b0.out_ready = or0;
    b0.flush     = fl;
    b1.in_valid  = iv1;
    b1.data_in   = d1;
    b1.out_ready = or1;
    b1.flush     = fl;
    #1;
    sb(0, b0.in_valid, b0.in_ready, b0.out_valid, b0.out_ready, b0.flush, rst,
       b0.data_in, b0.data_out);
    sb(1, b1.in_valid, b1.in_ready, b1.out_valid, b1.out_ready, b1.flush, rst,
       b1.data_in, b1.data_out);
    @(posedge clk);
    #1;
  endtask

  task automatic dcyc(input logic iv, input logic [31:0] d, input logic ordy,
                      input logic fl, input logic rs);
    cyc(iv, d, iv, d, ordy, ordy, fl, rs);
  endtask

  initial begin
    int sent0;
    int sent1;
    logic iv0;
    logic iv1;
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 2; k++) begin
      hold[k]      = 1'b0;
      hold_data[k] = 32'h0;
      fired[k]     = 1'b0;
      recv[k]      = 0;
    end
    rst          = 1'b1;
    b0.in_valid  = 1'b0;
    b0.data_in   = 32'h0;
    b0.out_ready = 1'b0;
    b0.flush     = 1'b0;
    b1.in_valid  = 1'b0;
    b1.data_in   = 32'h0;
    b1.out_ready = 1'b0;
    b1.flush     = 1'b0;

    // Reset with a valid word offered
    dcyc(1'b1, 32'h0000_0030, 1'b1, 1'b0, 1'b1);
    dcyc(1'b1, 32'h0000_0030, 1'b1, 1'b0, 1'b1);
    chk("rst_data0",  b0.data_out, 32'h0);
    chk("rst_valid0", 32'(b0.out_valid), 32'd0);
    chk("rst_level0", 32'(b0.level), 32'd0);
    chk("rst_data1",  b1.data_out, RV1);
    chk("rst_valid1", 32'(b1.out_valid), 32'd0);
    dcyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_ready0", 32'(b0.in_ready), 32'd1);
    chk("post_rst_ready1", 32'(b1.in_ready), 32'd1);
    chk("post_rst_valid0", 32'(b0.out_valid), 32'd0);

    // Back-to-back words with downstream always ready
    dcyc(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0);
    chk("b2b_data_a0",  b0.data_out, 32'hA5A5_A5A5);
    chk("b2b_valid_a0", 32'(b0.out_valid), 32'd1);
    chk("b2b_level_a0", 32'(b0.level), 32'd1);
    chk("b2b_data_a1",  b1.data_out, 32'hA5A5_A5A5);
    dcyc(1'b1, 32'h5A5A_5A5A, 1'b1, 1'b0, 1'b0);
    chk("b2b_data_b0",  b0.data_out, 32'h5A5A_5A5A);
    chk("b2b_valid_b0", 32'(b0.out_valid), 32'd1);
    chk("b2b_level_b0", 32'(b0.level), 32'd1);
    chk("b2b_data_b1",  b1.data_out, 32'h5A5A_5A5A);
    dcyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("b2b_idle_valid0", 32'(b0.out_valid), 32'd0);
    chk("b2b_idle_level0", 32'(b0.level), 32'd0);

    // Skid fill with downstream stalled, then release
    dcyc(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    chk("fill1_level0", 32'(b0.level), 32'd1);
    chk("fill1_ready0", 32'(b0.in_ready), 32'd1);
    dcyc(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    chk("fill2_level0", 32'(b0.level), 32'd2);
    chk("fill2_ready0", 32'(b0.in_ready), 32'd0);
    dcyc(1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    chk("fill3_level0", 32'(b0.level), 32'd2);
    chk("fill3_data0",  b0.data_out, 32'h1111_1111);
    dcyc(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
    chk("drain1_data0",  b0.data_out, 32'h2222_2222);
    chk("drain1_valid0", 32'(b0.out_valid), 32'd1);
    chk("drain1_level0", 32'(b0.level), 32'd1);
    chk("drain1_ready0", 32'(b0.in_ready), 32'd1);
    dcyc(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
    chk("drain2_data0",  b0.data_out, 32'h3333_3333);
    chk("drain2_valid0", 32'(b0.out_valid), 32'd1);
    dcyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain3_valid0", 32'(b0.out_valid), 32'd0);

    // Flush while full, and while accepting a word
    dcyc(1'b1, 32'hC1C1_C1C1, 1'b0, 1'b0, 1'b0);
    dcyc(1'b1, 32'hC2C2_C2C2, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_level0", 32'(b0.level), 32'd2);
    dcyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    chk("flush_valid0", 32'(b0.out_valid), 32'd0);
    chk("flush_level0", 32'(b0.level), 32'd0);
    chk("flush_ready0", 32'(b0.in_ready), 32'd1);
    chk("flush_data0",  b0.data_out, 32'hC1C1_C1C1);
    chk("flush_valid1", 32'(b1.out_valid), 32'd0);
    dcyc(1'b1, 32'hE1E1_E1E1, 1'b0, 1'b0, 1'b0);
    chk("refill_level0", 32'(b0.level), 32'd1);
    dcyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    chk("flush_drop_valid0", 32'(b0.out_valid), 32'd0);
    chk("flush_drop_level0", 32'(b0.level), 32'd0);
    chk("flush_drop_data0",  b0.data_out, 32'hE1E1_E1E1);
    chk("flush_drop_valid1", 32'(b1.out_valid), 32'd0);
    chk("flush_drop_level1", 32'(b1.level), 32'd0);
    dcyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_flush_valid0", 32'(b0.out_valid), 32'd0);

    // Reset while full, then a fresh push
    dcyc(1'b1, 32'hF1F1_F1F1, 1'b0, 1'b0, 1'b0);
    dcyc(1'b1, 32'hF2F2_F2F2, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level0", 32'(b0.level), 32'd2);
    dcyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_data0",  b0.data_out, 32'h0);
    chk("mid_rst_valid0", 32'(b0.out_valid), 32'd0);
    chk("mid_rst_level0", 32'(b0.level), 32'd0);
    chk("mid_rst_data1",  b1.data_out, RV1);
    dcyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_ready0", 32'(b0.in_ready), 32'd1);
    dcyc(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    chk("post_rst_push_data0",  b0.data_out, 32'h1234_5678);
    chk("post_rst_push_valid0", 32'(b0.out_valid), 32'd1);
    chk("post_rst_push_data1",  b1.data_out, 32'h1234_5678);
    dcyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random stalls on both sides, 1000 incrementing words per instance
    recv[0] = 0;
    recv[1] = 0;
    sent0   = 0;
    sent1   = 0;
    for (int i = 0; i < 8000 && (recv[0] < 1000 || recv[1] < 1000); i++) begin
      iv0 = (sent0 < 1000) && ($urandom_range(0, 3) != 0);
      iv1 = (sent1 < 1000) && ($urandom_range(0, 3) != 0);
      cyc(iv0, 32'h1000_0000 + 32'(sent0), iv1, 32'h2000_0000 + 32'(sent1),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (fired[0]) sent0++;
      if (fired[1]) sent1++;
    end
    chk("rand_sent0", 32'(sent0), 32'd1000);
    chk("rand_sent1", 32'(sent1), 32'd1000);
    chk("rand_recv0", 32'(recv[0]), 32'd1000);
    chk("rand_recv1", 32'(recv[1]), 32'd1000);
    chk("rand_left0", 32'(q0.size()), 32'd0);
    chk("rand_left1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
